// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers used by the timing generator and
// by the downstream cell-automaton and pixel stages.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_BOTTOM  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_TOP     = 33;

  function automatic int axis_total(input int disp, input int front,
                                    input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_BOTTOM, DEF_V_SYNC, DEF_V_TOP);

  // One timing axis as seen by the top: registered position and window flags,
  // plus the position that the next enabled edge will load.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next;
    logic             wrap;
    logic             sync_win;
    logic             active_win;
  } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one VGA axis with registered sync and active
// window flags decoded from the value being loaded (no counter/decode skew).
import vga_timing_pkg::*;

module vga_axis_counter #(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_DISPLAY,
  parameter int SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output axis_state_t axis
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             sync_q;
  logic             active_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Reset parks the counter on its last position so the first enabled edge
  // wraps to 0 and starts a fresh line/frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= LAST;
      sync_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (en) begin
      count_q  <= count_d;
      sync_q   <= (count_d >= SYNC_LO) && (count_d < SYNC_HI);
      active_q <= (count_d < ACT_END);
    end
  end

  always_comb begin
    axis.count      = count_q;
    axis.next       = count_d;
    axis.wrap       = (count_q == LAST);
    axis.sync_win   = sync_q;
    axis.active_win = active_q;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, display
// window, line/frame/cell strobes and a wrapping frame counter.
import vga_timing_pkg::*;

module vga_timing_gen #(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_BOTTOM  = DEF_V_BOTTOM,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_TOP     = DEF_V_TOP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOG_CELL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             cell_tick,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'((1 << LOG_CELL) - 1);

  axis_state_t h_axis;
  axis_state_t v_axis;
  logic        v_en;
  logic        line_wrap;
  logic        frame_wrap;
  logic        cell_hit;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (ce),
    .axis  (h_axis)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_BOTTOM),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .axis  (v_axis)
  );

  assign v_en       = ce & h_axis.wrap;
  assign line_wrap  = ce & h_axis.wrap;
  assign frame_wrap = line_wrap & v_axis.wrap;

  // Qualify on the position being loaded so the strobe lines up with it.
  assign cell_hit = ce && (h_axis.next < H_ACT_END) && (v_axis.next < V_ACT_END)
                    && ((h_axis.next & CELL_MASK) == CELL_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cell_tick   <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= line_wrap;
      frame_start <= frame_wrap;
      cell_tick   <= cell_hit;
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign hpos       = h_axis.count;
  assign vpos       = v_axis.count;
  assign hsync      = h_axis.sync_win ? HSYNC_POL : ~HSYNC_POL;
  assign vsync      = v_axis.sync_win ? VSYNC_POL : ~VSYNC_POL;
  assign display_on = h_axis.active_win & v_axis.active_win;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a reduced-geometry instance checked
// cycle by cycle against a reference model, plus default and wrap instances.
module tb_vga_timing_gen;

  localparam int HD = 16, HF = 4, HS = 6, HB = 6;
  localparam int VD = 12, VB = 2, VS = 3, VT_P = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VB + VS + VT_P;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam int LC = 2;
  localparam int W = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main, rst_aux, ce, ce_aux;

  logic [9:0]  hpos, vpos;
  logic        hsync, vsync, display_on, line_start, frame_start, cell_tick;
  logic [15:0] frame_count;

  logic [9:0]  d_hpos, d_vpos;
  logic        d_hsync, d_vsync, d_disp, d_ls, d_fs, d_ct;
  logic [15:0] d_fc;

  logic [9:0]  w_hpos, w_vpos;
  logic        w_hsync, w_vsync, w_disp, w_ls, w_fs, w_ct;
  logic [15:0] w_fc;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT_P),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP), .LOG_CELL(LC)
  ) u_dut (
    .clk(clk), .reset(rst_main), .ce(ce),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .cell_tick(cell_tick),
    .frame_count(frame_count)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_aux), .ce(ce_aux),
    .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_disp), .line_start(d_ls), .frame_start(d_fs),
    .cell_tick(d_ct), .frame_count(d_fc)
  );

  // 1x1 raster: every enabled edge starts a frame, so the 16-bit wrap is reachable.
  vga_timing_gen #(
    .H_DISPLAY(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
    .V_DISPLAY(1), .V_BOTTOM(0), .V_SYNC(0), .V_TOP(0),
    .LOG_CELL(1)
  ) u_wrap (
    .clk(clk), .reset(rst_aux), .ce(ce_aux),
    .hpos(w_hpos), .vpos(w_vpos), .hsync(w_hsync), .vsync(w_vsync),
    .display_on(w_disp), .line_start(w_ls), .frame_start(w_fs),
    .cell_tick(w_ct), .frame_count(w_fc)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  int          mh, mv;
  logic        mls, mfs, mct;
  logic [15:0] mfc;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, cell_tick, frame_count};
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic hs, vs, disp;
    hs   = (mh >= HD + HF && mh < HD + HF + HS) ? HSP : ~HSP;
    vs   = (mv >= VD + VB && mv < VD + VB + VS) ? VSP : ~VSP;
    disp = (mh < HD) && (mv < VD);
    return {10'(mh), 10'(mv), hs, vs, disp, mls, mfs, mct, mfc};
  endfunction

  task automatic model_reset();
    mh = HT - 1; mv = VT - 1;
    mls = 1'b0; mfs = 1'b0; mct = 1'b0;
    mfc = 16'd0;
  endtask

  task automatic model_step(input logic c);
    mls = 1'b0; mfs = 1'b0; mct = 1'b0;
    if (c) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mls = (mh == 0);
      mfs = (mh == 0) && (mv == 0);
      mct = (mh < HD) && (mv < VD) && ((mh % (1 << LC)) == (1 << LC) - 1);
      if (mfs) mfc = mfc + 16'd1;
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      check(tag, dut_vec(), e);
    end
  endtask

  task automatic step(input logic c, input string tag);
    model_step(c);
    exp_q.push_back(model_vec());
    ce = c;
    @(posedge clk);
    #1;
    sb_compare(tag);
  endtask

  // Statistics of the default-geometry instance over its first two lines.
  int d_edges    = 0;
  int d_hs_low   = 0;
  int d_hs_first = -1;
  int d_disp_cnt = 0;
  int d_ct_cnt   = 0;
  int d_ls_cnt   = 0;
  int d_fs_cnt   = 0;

  always @(posedge clk) begin
    if (rst_aux) d_edges <= 0;
    else         d_edges <= d_edges + 1;
  end

  always @(negedge clk) begin
    if (!rst_aux && d_edges >= 1 && d_edges <= 1600) begin
      if (!d_hsync) begin
        d_hs_low <= d_hs_low + 1;
        if (d_hs_first == -1) d_hs_first <= int'(d_hpos);
      end
      if (d_disp) d_disp_cnt <= d_disp_cnt + 1;
      if (d_ct)   d_ct_cnt   <= d_ct_cnt + 1;
      if (d_ls)   d_ls_cnt   <= d_ls_cnt + 1;
      if (d_fs)   d_fs_cnt   <= d_fs_cnt + 1;
    end
  end

  initial begin
    bit found;
    int guard;
    rst_main = 1'b1;
    rst_aux  = 1'b1;
    ce       = 1'b1;
    ce_aux   = 1'b1;
    model_reset();

    #1;
    exp_q.push_back(model_vec());
    sb_compare("reset_async");
    check("def_reset_hpos", W'(d_hpos), W'(799));
    check("def_reset_vpos", W'(d_vpos), W'(524));
    check("def_reset_syncs", W'({d_hsync, d_vsync, d_disp, d_fc}), W'({1'b1, 1'b1, 1'b0, 16'd0}));

    repeat (2) begin
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      sb_compare("reset_overrides_ce");
    end

    @(negedge clk);
    rst_main = 1'b0;
    rst_aux  = 1'b0;

    step(1'b1, "first_edge");
    for (int i = 0; i < 1300; i++) step(1'b1, "run_ce1");
    for (int i = 0; i < 200; i++)  step(i % 2 == 0, "ce_toggle");
    for (int i = 0; i < 400; i++)  step(1'($urandom_range(0, 1)), "ce_random");
    for (int i = 0; i < 20; i++)   step(1'b0, "ce_hold");

    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      if (mh == 10 && mv == 6) found = 1'b1;
      else step(1'b1, "seek_midframe");
    end
    check("seek_midframe_bound", W'(found), W'(1));

    @(negedge clk);
    #2;
    rst_main = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    sb_compare("reset_midframe_async");
    ce = 1'b1;
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    sb_compare("reset_midframe_hold");
    @(negedge clk);
    rst_main = 1'b0;
    step(1'b1, "after_reset_first");
    for (int i = 0; i < 40; i++) step(1'b1, "after_reset_run");

    check("def_hsync_low_clks", W'(d_hs_low), W'(192));
    check("def_hsync_first_hpos", W'(d_hs_first), W'(656));
    check("def_display_clks", W'(d_disp_cnt), W'(1280));
    check("def_cell_ticks", W'(d_ct_cnt), W'(320));
    check("def_line_starts", W'(d_ls_cnt), W'(2));
    check("def_frame_starts", W'(d_fs_cnt), W'(1));

    guard = 0;
    while (d_edges < 65535 && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_wait_bound", W'(d_edges), W'(65535));
    check("wrap_ffff", W'({w_fc, w_fs}), W'({16'hFFFF, 1'b1}));
    @(negedge clk);
    check("wrap_to_zero", W'({w_fc, w_fs, w_hpos, w_vpos}), W'({16'h0000, 1'b1, 10'd0, 10'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameters V_BOTTOM/V_SYNC/V_TOP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 Parameters HSYNC_POL/VSYNC_POL, default 0/0, active level of each sync output (0 = active-low).
REQ-006 Parameter LOG_CELL, default 2, log2 of cell size in pixels for cell_tick.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 ce  input  1  pixel-clock enable; counters advance only on edges with ce=1.
REQ-010 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-011 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-012 hsync / vsync  output  1 each  sync pulses at configured polarity.
REQ-013 display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-014 line_start / frame_start / cell_tick  output  1 each  single-clk strobes.
REQ-015 frame_count  output  16  frames started since reset, wrapping.

Function
REQ-016 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP (default 525).
REQ-017 On a ce=1 edge: hpos increments; at H_TOTAL-1, hpos wraps to 0 and vpos increments; at vpos V_TOTAL-1 with hpos wrap, vpos wraps to 0.
REQ-018 On a ce=0 edge: hpos, vpos, hsync, vsync, display_on and frame_count hold.
REQ-019 hsync active exactly while H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (default 656..751).
REQ-020 vsync active exactly while V_DISPLAY+V_BOTTOM <= vpos < V_DISPLAY+V_BOTTOM+V_SYNC (default 490..491).
REQ-021 hsync, vsync and display_on are registered and change on the same edge as the hpos/vpos value they decode; zero cycles of skew between counters and decodes.
REQ-022 line_start is high for exactly one clk cycle after each ce=1 edge that loads hpos=0.
REQ-023 frame_start is high for exactly one clk cycle after each ce=1 edge that loads (hpos,vpos)=(0,0); line_start is also high in that cycle.
REQ-024 cell_tick is high for one clk cycle after each ce=1 edge that loads an hpos with hpos<H_DISPLAY, vpos<V_DISPLAY and hpos[LOG_CELL-1:0]=all ones (last pixel of a cell).
REQ-025 All strobes are 0 in any cycle following a ce=0 edge, even when counters hold a qualifying value.
REQ-026 frame_count increments by 1, modulo 2^16, on the same edge that asserts frame_start; 0xFFFF wraps to 0x0000.
REQ-027 Counter compare widths are 10 bits; H_TOTAL and V_TOTAL above 1024 are unsupported.

Reset
REQ-028 While reset is high: hpos=H_TOTAL-1, vpos=V_TOTAL-1, hsync and vsync inactive, display_on=0, all strobes 0, frame_count=0.
REQ-029 First ce=1 edge after reset release loads (0,0), asserts frame_start and line_start, and sets frame_count=1.
REQ-030 Reset asserted mid-frame takes effect immediately, without waiting for a clock edge, and overrides ce.

Structure
REQ-031 Default timing constants and derived H_TOTAL/V_TOTAL belong in shared package vga_timing_pkg, reused by the cell-automaton and pixel stages.
REQ-032 One sub-module, vga_axis_counter, is instantiated twice: horizontal (enable=ce) and vertical (enable=ce and horizontal wrap). It provides counter, wrap flag, sync window and active window.

Verification
REQ-033 Reset, then ce=1 continuously for 2 frames -> frame_start every 420000 clks, frame_count 1 then 2, hsync low for 96 clks per line starting at hpos=656.
REQ-034 Full frame at defaults -> vsync low exactly for lines 490-491 (1600 clks), display_on high for exactly 307200 clks.
REQ-035 ce toggled 1,0,1,0 -> hpos advances once per two clks and strobes never exceed one clk of width.
REQ-036 In active video -> cell_tick once per 4 pixels at hpos 3, 7, ..., 639; 160 per line; none during blanking.
REQ-037 Preload via 65535 frames, or a forced frame_count of 0xFFFF -> next frame_start gives frame_count=0x0000.
REQ-038 Assert reset at hpos=300, vpos=200 between clk edges -> outputs immediately take REQ-028 values; after release, first ce edge gives (0,0) with frame_start=1.
